sprite_blitter: RTL and testbench

SPRITE_BLITTER -- requirements
Module: sprite_blitter

---
 rtl/video_pkg.sv | 13 +
 rtl/sprite_rom.sv | 19 +
 rtl/sprite_blitter.sv | 112 +++++++++++
 tb/tb_sprite_blitter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video constants and the blitter state encoding.
package video_pkg;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int IDX_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } blit_state_t;
endpackage

// File: rtl/sprite_rom.sv
// Synchronous sprite ROM, one palette index per address, 1-cycle read latency.
// INIT is the flattened .mem image: entry a lives at bits [a*IDX_W +: IDX_W].
module sprite_rom
    import video_pkg::*;
#(
    parameter int                       DEPTH = 4096,
    parameter int                       AW    = 12,
    parameter logic [DEPTH*IDX_W-1:0]   INIT  = '0
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr,
    output logic [IDX_W-1:0] data
);

    always_ff @(posedge clk) begin
        data <= INIT[addr*IDX_W +: IDX_W];
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: streams one ROM sprite into the framebuffer, one pixel per
// cycle, with transparency and screen-edge clipping.
module sprite_blitter
    import video_pkg::*;
#(
    parameter int                                SPR_W      = 32,
    parameter int                                SPR_H      = 32,
    parameter logic [IDX_W-1:0]                  TRANSP_IDX = 4'h0,
    parameter logic [4*SPR_W*SPR_H*IDX_W-1:0]    ROM_INIT   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [9:0]       sprite_x,
    input  logic [8:0]       sprite_y,
    input  logic [1:0]       sprite_id,
    output logic             busy,
    output logic             done,
    output logic             fb_we,
    output logic [9:0]       fb_write_x,
    output logic [8:0]       fb_write_y,
    output logic [IDX_W-1:0] fb_write_index
);

    localparam int CW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);
    localparam int PW = CW + RW;
    localparam int AW = PW + 2;

    blit_state_t      state, state_nx;
    logic [PW-1:0]    pix_cnt;
    logic [9:0]       org_x;
    logic [8:0]       org_y;
    logic [1:0]       id_q;
    logic [CW-1:0]    col_s1;
    logic [RW-1:0]    row_s1;
    logic [1:0]       vld_pipe;
    logic             keep_q;
    logic [IDX_W-1:0] rom_data;
    logic [10:0]      px_x;
    logic [9:0]       px_y;
    logic             keep;

    sprite_rom #(
        .DEPTH (4 * SPR_W * SPR_H),
        .AW    (AW),
        .INIT  (ROM_INIT)
    ) u_rom (
        .clk  (clk),
        .addr ({id_q, pix_cnt}),
        .data (rom_data)
    );

    // Coordinates are widened so off-screen pixels clip instead of wrapping.
    assign px_x  = {1'b0, org_x} + 11'(col_s1);
    assign px_y  = {1'b0, org_y} + 10'(row_s1);
    assign keep  = (rom_data != TRANSP_IDX) && (px_x < 11'(SCREEN_W)) && (px_y < 10'(SCREEN_H));
    assign fb_we = vld_pipe[1] & keep_q;

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = (state == DONE);
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (pix_cnt == '1) state_nx = FLUSH;
            FLUSH:   if (!vld_pipe[0]) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            pix_cnt        <= '0;
            org_x          <= '0;
            org_y          <= '0;
            id_q           <= '0;
            col_s1         <= '0;
            row_s1         <= '0;
            vld_pipe       <= '0;
            keep_q         <= 1'b0;
            fb_write_x     <= '0;
            fb_write_y     <= '0;
            fb_write_index <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                org_x   <= sprite_x;
                org_y   <= sprite_y;
                id_q    <= sprite_id;
                pix_cnt <= '0;
            end else if (state == RUN) begin
                pix_cnt <= pix_cnt + 1'b1;
            end
            // Stage 1 tracks the ROM read; stage 2 is the registered fb write.
            vld_pipe <= {vld_pipe[0], state == RUN};
            col_s1   <= pix_cnt[CW-1:0];
            row_s1   <= pix_cnt[PW-1:CW];
            if (vld_pipe[0]) begin
                fb_write_x     <= px_x[9:0];
                fb_write_y     <= px_y[8:0];
                fb_write_index <= rom_data;
                keep_q         <= keep;
            end else begin
                keep_q         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter: expected writes queued at start, popped per fb_we.
module tb_sprite_blitter;

    // Sprite 0 solid 5, sprite 1 checkerboard 0/3, sprite 2 solid 9, sprite 3 index = col mod 16.
    localparam logic [4095:0]  S0 = {1024{4'h5}};
    localparam logic [4095:0]  S1 = {16{{16{8'h03}}, {16{8'h30}}}};
    localparam logic [4095:0]  S2 = {1024{4'h9}};
    localparam logic [4095:0]  S3 = {64{64'hfedcba9876543210}};
    localparam logic [16383:0] ROM_IMG = {S3, S2, S1, S0};

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        logic [3:0] idx;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [9:0] sprite_x;
    logic [8:0] sprite_y;
    logic [1:0] sprite_id;
    logic       busy, done, fb_we;
    logic [9:0] fb_write_x;
    logic [8:0] fb_write_y;
    logic [3:0] fb_write_index;

    wr_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  wr_cnt = 0;
    int  done_cnt = 0;
    int  first_wr = -1;

    sprite_blitter #(
        .SPR_W(32), .SPR_H(32), .TRANSP_IDX(4'h0), .ROM_INIT(ROM_IMG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_id(sprite_id),
        .busy(busy), .done(done), .fb_we(fb_we),
        .fb_write_x(fb_write_x), .fb_write_y(fb_write_y), .fb_write_index(fb_write_index)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_px(input int id, input int row, input int col);
        case (id)
            0:       return 4'h5;
            1:       return ((row + col) % 2 == 1) ? 4'h3 : 4'h0;
            2:       return 4'h9;
            default: return 4'(col % 16);
        endcase
    endfunction

    task automatic push_expected(input int x, input int y, input int id, output int cnt);
        wr_t e;
        cnt = 0;
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) begin
                if (ref_px(id, r, c) != 4'h0 && x + c < 640 && y + r < 480) begin
                    e.x = 10'(x + c); e.y = 9'(y + r); e.idx = ref_px(id, r, c);
                    sb.push_back(e);
                    cnt++;
                end
            end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (fb_we) begin
            wr_cnt++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got x=%0d y=%0d idx=%0d, required no write",
                         fb_write_x, fb_write_y, fb_write_index);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if ({fb_write_x, fb_write_y, fb_write_index} !== {e.x, e.y, e.idx}) begin
                    n_bad++;
                    $display("FAIL pixel_write: got x=%0d y=%0d idx=%0d, required x=%0d y=%0d idx=%0d",
                             fb_write_x, fb_write_y, fb_write_index, e.x, e.y, e.idx);
                end
            end
        end
    end

    // Runs one blit; returns edges from start edge to done, and the expected write count.
    task automatic do_blit(input int x, input int y, input int id, input bit no_wait,
                           input int pa, input int pb, input bit pd,
                           output int lat, output int exp_wr);
        wr_cnt = 0; done_cnt = 0; first_wr = -1; lat = -1;
        push_expected(x, y, id, exp_wr);
        if (!no_wait) @(negedge clk);
        start = 1'b1; sprite_x = 10'(x); sprite_y = 9'(y); sprite_id = 2'(id);
        @(posedge clk);
        #1;
        start = 1'b0; sprite_x = 10'd777; sprite_y = 9'd333; sprite_id = 2'(id + 1);
        for (int n = 1; n <= 3000 && lat < 0; n++) begin
            @(negedge clk);
            start = (n == pa || n == pb);
            if (fb_we && first_wr < 0) first_wr = n - 1;
            if (done) begin
                lat = n - 1;
                start = pd;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; sprite_x = '0; sprite_y = '0; sprite_id = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b required 0", done); end
        n_cmp++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b required 0", fb_we); end
        n_cmp++; if ({fb_write_x, fb_write_y, fb_write_index} !== 23'd0) begin
            n_bad++; $display("FAIL reset_fb: got x=%0d y=%0d idx=%0d required 0", fb_write_x, fb_write_y, fb_write_index);
        end
        rst_n = 1'b1;
    endtask

    task automatic check_blit(input string name, input int lat, input int exp_wr);
        n_cmp++; if (lat !== 1026) begin n_bad++; $display("FAIL %s_latency: got %0d required 1026", name, lat); end
        n_cmp++; if (first_wr !== 2 && exp_wr == 1024) begin n_bad++; $display("FAIL %s_first_write: got %0d required 2", name, first_wr); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++; $display("FAIL %s_after_done: got busy=%b done=%b required 0/0", name, busy, done);
        end
        n_cmp++; if (wr_cnt !== exp_wr) begin n_bad++; $display("FAIL %s_writes: got %0d required %0d", name, wr_cnt, exp_wr); end
        n_cmp++; if (sb.size() !== 0) begin n_bad++; $display("FAIL %s_missing: got %0d left required 0", name, sb.size()); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL %s_done_count: got %0d required 1", name, done_cnt); end
        sb.delete();
    endtask

    task automatic test_solid;
        int lat, ew;
        do_blit(100, 50, 0, 1'b0, 0, 0, 1'b0, lat, ew);
        n_cmp++; if (ew !== 1024) begin n_bad++; $display("FAIL solid_model: got %0d required 1024", ew); end
        check_blit("solid", lat, ew);
    endtask

    task automatic test_checker;
        int lat, ew;
        do_blit(200, 100, 1, 1'b0, 0, 0, 1'b0, lat, ew);
        check_blit("checker", lat, 512);
    endtask

    task automatic test_clip;
        int lat, ew;
        do_blit(620, 470, 2, 1'b0, 0, 0, 1'b0, lat, ew);
        check_blit("clip", lat, 200);
    endtask

    task automatic test_start_ignored;
        int lat, ew;
        do_blit(10, 10, 3, 1'b0, 10, 500, 1'b1, lat, ew);
        check_blit("ignored", lat, 960);
        start = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || done_cnt !== 1) begin
            n_bad++; $display("FAIL ignored_idle: got busy=%b dones=%0d required 0/1", busy, done_cnt);
        end
        do_blit(0, 0, 2, 1'b0, 0, 0, 1'b0, lat, ew);
        check_blit("accept_after", lat, 1024);
    endtask

    task automatic test_reset_mid;
        int ew, lat;
        wr_cnt = 0; done_cnt = 0;
        push_expected(0, 0, 0, ew);
        @(negedge clk);
        start = 1'b1; sprite_x = '0; sprite_y = '0; sprite_id = 2'd0;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 300; n++) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        n_cmp++; if (wr_cnt !== 298) begin n_bad++; $display("FAIL abort_writes_before: got %0d required 298", wr_cnt); end
        n_cmp++; if ({fb_we, fb_write_x, fb_write_y, fb_write_index} !== 24'd0) begin
            n_bad++; $display("FAIL abort_fb_cleared: got we=%b x=%0d y=%0d idx=%0d required 0",
                              fb_we, fb_write_x, fb_write_y, fb_write_index);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || done_cnt !== 0 || wr_cnt !== 298) begin
            n_bad++; $display("FAIL abort_quiet: got busy=%b dones=%0d writes=%0d required 0/0/298", busy, done_cnt, wr_cnt);
        end
        do_blit(300, 200, 3, 1'b0, 0, 0, 1'b0, lat, ew);
        check_blit("after_abort", lat, 960);
    endtask

    task automatic test_back_to_back;
        int lat, ew;
        do_blit(40, 60, 0, 1'b0, 0, 0, 1'b0, lat, ew);
        n_cmp++; if (lat !== 1026) begin n_bad++; $display("FAIL b2b_first_latency: got %0d required 1026", lat); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || wr_cnt !== 1024) begin
            n_bad++; $display("FAIL b2b_first_end: got busy=%b writes=%0d required 0/1024", busy, wr_cnt);
        end
        do_blit(64, 32, 1, 1'b1, 0, 0, 1'b0, lat, ew);
        check_blit("b2b_second", lat, 512);
    endtask

    initial begin
        test_reset();
        test_solid();
        test_checker();
        test_clip();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
